// File: rtl/dispense_ctrl_if.sv
//------------------------------------------------------------------------------
// dispense_ctrl_if
// Bundles the request, sensor, actuator and status signals exchanged between
// the upstream vending logic / machine hardware (master side) and the
// dispense controller (slave side).
//
// Signals:
//   deliver_tea     master->slave  tea dispense request (level)
//   deliver_coffee  master->slave  coffee dispense request (level)
//   change          master->slave  return-one-coin request, qualified by a deliver
//   cup_sensor      master->slave  drop sensor, high when an item has landed
//   fault_clr       master->slave  operator fault clear
//   motor_tea       slave->master  tea motor drive
//   motor_coffee    slave->master  coffee motor drive
//   coin_return     slave->master  single-cycle coin-return pulse
//   busy            slave->master  controller is not idle
//   fault           slave->master  controller is in the fault state
//   tea_served      slave->master  successful tea dispenses (8 bit, saturating)
//   coffee_served   slave->master  successful coffee dispenses (8 bit, saturating)
//------------------------------------------------------------------------------
interface dispense_ctrl_if;
    logic       deliver_tea;
    logic       deliver_coffee;
    logic       change;
    logic       cup_sensor;
    logic       fault_clr;
    logic       motor_tea;
    logic       motor_coffee;
    logic       coin_return;
    logic       busy;
    logic       fault;
    logic [7:0] tea_served;
    logic [7:0] coffee_served;

    modport master (
        output deliver_tea, deliver_coffee, change, cup_sensor, fault_clr,
        input  motor_tea, motor_coffee, coin_return, busy, fault,
               tea_served, coffee_served
    );

    modport slave (
        input  deliver_tea, deliver_coffee, change, cup_sensor, fault_clr,
        output motor_tea, motor_coffee, coin_return, busy, fault,
               tea_served, coffee_served
    );
endinterface

// File: rtl/dispense_ctrl.sv
//------------------------------------------------------------------------------
// dispense_ctrl
// Drink dispense sequencer. Accepts a tea or coffee request while idle, drives
// the matching motor for MOTOR_CYCLES cycles, waits up to TIMEOUT_CYCLES cycles
// for the drop sensor, optionally pulses a coin return, and latches a fault
// when the item never lands. All outputs apart from the counters are Moore
// decodes of the registered state.
//
// Parameters:
//   MOTOR_CYCLES    motor drive length per dispense (1..255)
//   TIMEOUT_CYCLES  drop-confirmation wait limit (1..255)
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   dispense_ctrl_if.slave (requests/sensor in, motors/status out)
//
// Configuration:
//   DISPENSE_STATS_EN  when defined, tea_served/coffee_served count confirmed
//                      dispenses and saturate at 255; when undefined the
//                      counter registers are absent and both outputs are 0.
//------------------------------------------------------------------------------
module dispense_ctrl #(
    parameter int unsigned MOTOR_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst,
    dispense_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RUN_TEA,
        RUN_COFFEE,
        WAIT_DROP,
        COIN,
        FAULT
    } state_t;

    // Timer runs 0..N-1, so the terminal value is N-1.
    localparam logic [7:0] MOTOR_LAST   = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] timer;
    logic       change_pending;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            timer          <= '0;
            change_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    // Tea has priority; change is only meaningful with a request.
                    if (bus.deliver_tea) begin
                        state          <= RUN_TEA;
                        change_pending <= bus.change;
                    end else if (bus.deliver_coffee) begin
                        state          <= RUN_COFFEE;
                        change_pending <= bus.change;
                    end
                end

                RUN_TEA, RUN_COFFEE: begin
                    if (timer == MOTOR_LAST) begin
                        state <= WAIT_DROP;
                        timer <= '0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                WAIT_DROP: begin
                    if (bus.cup_sensor) begin
                        state          <= change_pending ? COIN : IDLE;
                        change_pending <= 1'b0;
                        timer          <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        // The item never landed: no count, no refund.
                        state          <= FAULT;
                        change_pending <= 1'b0;
                        timer          <= '0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                COIN: begin
                    state <= IDLE;
                end

                FAULT: begin
                    if (bus.fault_clr) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state          <= IDLE;
                    timer          <= '0;
                    change_pending <= 1'b0;
                end
            endcase
        end
    end

    assign bus.motor_tea    = (state == RUN_TEA);
    assign bus.motor_coffee = (state == RUN_COFFEE);
    assign bus.coin_return  = (state == COIN);
    assign bus.busy         = (state != IDLE);
    assign bus.fault        = (state == FAULT);

`ifdef DISPENSE_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] tea_cnt;
    logic [7:0] coffee_cnt;
    logic       item_coffee;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tea_cnt     <= '0;
            coffee_cnt  <= '0;
            item_coffee <= 1'b0;
        end else begin
            // Remember the product on the accept edge; outside an accept the
            // value is overwritten before it is ever used.
            if (state == IDLE) begin
                item_coffee <= !bus.deliver_tea;
            end
            if (state == WAIT_DROP && bus.cup_sensor) begin
                if (item_coffee) begin
                    coffee_cnt <= sat_inc(coffee_cnt);
                end else begin
                    tea_cnt <= sat_inc(tea_cnt);
                end
            end
        end
    end

    assign bus.tea_served    = tea_cnt;
    assign bus.coffee_served = coffee_cnt;
`else
    assign bus.tea_served    = 8'd0;
    assign bus.coffee_served = 8'd0;
`endif

endmodule

// File: tb/tb_dispense_ctrl.sv
//------------------------------------------------------------------------------
// tb_dispense_ctrl
// Self-checking bench for dispense_ctrl with MOTOR_CYCLES=4, TIMEOUT_CYCLES=8.
// Expected behaviour comes from a transaction-level model: each request is
// expanded into its motor, wait, coin and fault phases with plain arithmetic,
// and confirmed dispenses are tallied in integer counters.
//------------------------------------------------------------------------------
module tb_dispense_ctrl;

    localparam int M  = 4;
    localparam int TO = 8;

`ifdef DISPENSE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;

    dispense_ctrl_if bus_if ();

    dispense_ctrl #(
        .MOTOR_CYCLES  (M),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int tea_m    = 0;
    int coffee_m = 0;

    function automatic int exp_cnt(input int m);
        if (!STATS) return 0;
        return (m > 255) ? 255 : m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic expect_out(input string ph, input bit mt, input bit mc,
                              input bit coin, input bit busy, input bit flt);
        chk({ph, ".motor_tea"},     32'(bus_if.motor_tea),     32'(mt));
        chk({ph, ".motor_coffee"},  32'(bus_if.motor_coffee),  32'(mc));
        chk({ph, ".coin_return"},   32'(bus_if.coin_return),   32'(coin));
        chk({ph, ".busy"},          32'(bus_if.busy),          32'(busy));
        chk({ph, ".fault"},         32'(bus_if.fault),         32'(flt));
        chk({ph, ".tea_served"},    32'(bus_if.tea_served),    32'(exp_cnt(tea_m)));
        chk({ph, ".coffee_served"}, 32'(bus_if.coffee_served), 32'(exp_cnt(coffee_m)));
    endtask

    task automatic zero_inputs();
        bus_if.deliver_tea    = 1'b0;
        bus_if.deliver_coffee = 1'b0;
        bus_if.change         = 1'b0;
        bus_if.cup_sensor     = 1'b0;
        bus_if.fault_clr      = 1'b0;
    endtask

    // Random traffic on inputs the controller must ignore while busy.
    task automatic junk();
        bus_if.deliver_tea    = 1'($urandom % 2);
        bus_if.deliver_coffee = 1'($urandom % 2);
        bus_if.change         = 1'($urandom % 2);
        bus_if.cup_sensor     = 1'($urandom % 2);
        bus_if.fault_clr      = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        zero_inputs();
        for (int i = 0; i < n; i++) step();
        tea_m    = 0;
        coffee_m = 0;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    // One complete request, starting and ending on an idle sample point.
    // d = number of low-sensor wait cycles before the item lands; d >= TO
    // means it never lands within the timeout.
    task automatic run_txn(input bit t, input bit c, input bit ch, input int d);
        bit is_tea;
        bit is_cof;
        bit ok;
        int last;
        int hold;
        is_tea = t;
        is_cof = !t && c;
        ok     = (d < TO);
        last   = ok ? d : TO - 1;

        bus_if.deliver_tea    = t;
        bus_if.deliver_coffee = c;
        bus_if.change         = ch;
        bus_if.cup_sensor     = 1'($urandom % 2);
        bus_if.fault_clr      = 1'b0;
        step();

        if (!is_tea && !is_cof) begin
            expect_out("noreq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            zero_inputs();
            return;
        end

        for (int i = 0; i < M; i++) begin
            expect_out("motor", is_tea, is_cof, 1'b0, 1'b1, 1'b0);
            junk();
            step();
        end

        for (int k = 0; k <= last; k++) begin
            expect_out("wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            junk();
            bus_if.cup_sensor = ok && (k == d);
            if (ok && k == d) begin
                if (is_tea) tea_m++;
                else coffee_m++;
            end
            step();
        end

        if (ok) begin
            if (ch) begin
                expect_out("coin", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                junk();
                step();
            end
        end else begin
            hold = $urandom_range(1, 4);
            for (int j = 0; j < hold; j++) begin
                expect_out("fault", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                junk();
                step();
            end
            expect_out("fault", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            junk();
            bus_if.fault_clr = 1'b1;
            step();
        end

        zero_inputs();
        expect_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        zero_inputs();
        do_reset(3);

        // Change without a request is ignored in IDLE.
        run_txn(1'b0, 1'b0, 1'b1, 0);

        // Plain tea, sensor two cycles after motor stop, no coin.
        run_txn(1'b1, 1'b0, 1'b0, 2);

        // Coffee with change.
        run_txn(1'b0, 1'b1, 1'b1, 3);

        // Both requests: tea wins, busy-time requests ignored.
        run_txn(1'b1, 1'b1, 1'b0, 1);

        // Sensor never fires: fault after motor + timeout.
        run_txn(1'b1, 1'b0, 1'b1, TO + 2);

        // Boundary: sensor lands on the last allowed wait cycle.
        run_txn(1'b0, 1'b1, 1'b0, TO - 1);

        // Back-to-back requests on the first idle cycle.
        run_txn(1'b1, 1'b0, 1'b1, 0);
        run_txn(1'b0, 1'b1, 1'b0, 0);

        // Reset in the middle of a coffee dispense.
        bus_if.deliver_coffee = 1'b1;
        step();
        expect_out("rst_mid", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        junk();
        step();
        expect_out("rst_mid", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset(1);

        // Randomised requests.
        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                    $urandom_range(0, TO + 3));
        end

        // Counter saturation.
        do_reset(2);
        for (int n = 0; n < 256; n++) begin
            run_txn(1'b1, 1'b0, 1'b0, 0);
        end
        chk("tea_saturated", 32'(bus_if.tea_served), 32'(STATS ? 255 : 0));
        run_txn(1'b0, 1'b1, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dispense_ctrl.md
DISPENSE_CTRL -- requirements
Module: dispense_ctrl

Interface
REQ-001 SHALL have parameter MOTOR_CYCLES, default 8: cycles the selected motor is driven per dispense, legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32: maximum wait cycles for drop confirmation, legal range 1..255.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port deliver_tea  input  1  tea dispense request, level from the upstream vending FSM.
REQ-006 SHALL have port deliver_coffee  input  1  coffee dispense request.
REQ-007 SHALL have port change  input  1  return-one-coin request, qualified by deliver_tea or deliver_coffee.
REQ-008 SHALL have port cup_sensor  input  1  drop sensor, high when an item has landed.
REQ-009 SHALL have port fault_clr  input  1  operator fault clear.
REQ-010 SHALL have port motor_tea  output  1  tea motor drive.
REQ-011 SHALL have port motor_coffee  output  1  coffee motor drive.
REQ-012 SHALL have port coin_return  output  1  single-cycle coin-return pulse.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port fault  output  1  high in FAULT.
REQ-015 SHALL have ports tea_served and coffee_served  output  8 each  successful-dispense counts.

Function
REQ-016 SHALL implement states IDLE, RUN_TEA, RUN_COFFEE, WAIT_DROP, COIN, FAULT; all outputs except counters Moore-decoded from the registered state.
REQ-017 In IDLE, deliver_tea high at an edge SHALL move to RUN_TEA; else deliver_coffee high SHALL move to RUN_COFFEE (tea wins when both high).
REQ-018 On that same edge SHALL latch change into change_pending; change without a deliver request in IDLE SHALL be ignored.
REQ-019 motor_tea (motor_coffee) SHALL be high for exactly MOTOR_CYCLES consecutive cycles in RUN_TEA (RUN_COFFEE), then enter WAIT_DROP.
REQ-020 In WAIT_DROP, cup_sensor high at an edge SHALL increment the matching counter and go to COIN if change_pending, else IDLE.
REQ-021 If cup_sensor stays low for TIMEOUT_CYCLES WAIT_DROP cycles, SHALL enter FAULT with no counter increment and change_pending cleared.
REQ-022 COIN SHALL last exactly one cycle with coin_return high, then IDLE.
REQ-023 FAULT SHALL hold fault=1, motors off, until fault_clr high at an edge, then IDLE.
REQ-024 deliver/change inputs SHALL be ignored in every state but IDLE; cup_sensor SHALL be ignored outside WAIT_DROP.
REQ-025 Counters SHALL saturate at 255, not wrap.
REQ-026 Earliest re-accept of a new request SHALL be the first IDLE cycle after return.

Reset
REQ-027 rst low at an edge SHALL force IDLE, clear change_pending, motor/cycle timers, both counters, and thereby all outputs to 0, from any state including mid-dispense.

Configuration
REQ-028 With macro DISPENSE_STATS_EN defined, tea_served/coffee_served SHALL behave per REQ-020/REQ-025.
REQ-029 Without DISPENSE_STATS_EN, counter registers SHALL be absent and tea_served/coffee_served SHALL be constant 0; all other behaviour unchanged.

Verification (MOTOR_CYCLES=4, TIMEOUT_CYCLES=8, DISPENSE_STATS_EN defined)
REQ-030 deliver_tea=1,change=0 one cycle; cup_sensor high 2 cycles after motor stop -> motor_tea high 4 cycles, tea_served 0->1, coin_return never high, busy low after.
REQ-031 deliver_coffee=1,change=1 -> motor_coffee 4 cycles, sensor confirm, coin_return exactly 1 cycle, coffee_served=1.
REQ-032 deliver_tea=1 and deliver_coffee=1 same edge -> only motor_tea asserted; second request during busy ignored.
REQ-033 deliver_tea, cup_sensor held low -> fault=1 after 4 motor + 8 wait cycles, tea_served unchanged, coin_return not pulsed; fault_clr -> IDLE, fault=0.
REQ-034 rst low during RUN_COFFEE cycle 2 -> next cycle motor_coffee=0, busy=0, counters 0.
REQ-035 256 confirmed tea dispenses -> tea_served holds 255.
